rf_access_arbiter: RTL and testbench

RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

---
 rtl/rf_access_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//
// Shares one single-ported register file between two requesters. A command
// is granted only while the controller is IDLE. Writes take two cycles
// (IDLE, ISSUE). Reads take three cycles (IDLE, ISSUE, CAPTURE) and end with
// a one-cycle response strobe.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   reqN_valid/ready        command handshake for requester N (N = 0, 1);
//                           ready is combinational and asserted only in IDLE
//   reqN_write              1 = write reqN_wdata to reqN_da, 0 = read
//   reqN_da/aa/ba           destination and operand register addresses
//   reqN_wdata              write data
//   rsp_valid               one-cycle read response strobe
//   rsp_id                  requester that owns the response
//   rsp_a/b/d               read data for AA, BA and DA; held until the next read
//   rf_reset                synchronous initialise request to the register file
//   rf_rw                   register file port mode, 0 = READ, 1 = WRITE
//   rf_da/aa/ba/wdata       registered register file command
//   rf_aout/bout/dout       register file read data, valid the cycle after a READ edge
//   busy                    high in every state except IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// INIT    | rf_reset high for one cycle after reset, no grants
// IDLE    | arbitrate, latch the winning command
// ISSUE   | drive rf_rw from the latched write flag for one cycle
// CAPTURE | register the register file read data into rsp_*
module rf_access_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_da,
    input  logic [ADDR_W-1:0] req0_aa,
    input  logic [ADDR_W-1:0] req0_ba,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_da,
    input  logic [ADDR_W-1:0] req1_aa,
    input  logic [ADDR_W-1:0] req1_ba,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic [DATA_W-1:0] rsp_d,

    output logic              rf_reset,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_da,
    output logic [ADDR_W-1:0] rf_aa,
    output logic [ADDR_W-1:0] rf_ba,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_aout,
    input  logic [DATA_W-1:0] rf_bout,
    input  logic [DATA_W-1:0] rf_dout,

    output logic              busy
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        ISSUE   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t state;

    // Last granted requester. It also names the owner of the command in
    // flight, so it doubles as the response id source in CAPTURE.
    logic last_grant;
    logic write_flag;

    logic              grant0;
    logic              grant1;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_da;
    logic [ADDR_W-1:0] cmd_aa;
    logic [ADDR_W-1:0] cmd_ba;
    logic [DATA_W-1:0] cmd_wdata;

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        cmd_write = req0_write;
        cmd_da    = req0_da;
        cmd_aa    = req0_aa;
        cmd_ba    = req0_ba;
        cmd_wdata = req0_wdata;
        if (grant1) begin
            cmd_write = req1_write;
            cmd_da    = req1_da;
            cmd_aa    = req1_aa;
            cmd_ba    = req1_ba;
            cmd_wdata = req1_wdata;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            rf_reset   <= 1'b1;
            rf_rw      <= 1'b0;
            rf_da      <= '0;
            rf_aa      <= '0;
            rf_ba      <= '0;
            rf_wdata   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_a      <= '0;
            rsp_b      <= '0;
            rsp_d      <= '0;
            busy       <= 1'b1;
            last_grant <= 1'b1;
            write_flag <= 1'b0;
        end else begin
            // Both strobes are single-cycle by default; only the transitions
            // below raise them.
            rf_rw     <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                INIT: begin
                    state    <= IDLE;
                    rf_reset <= 1'b0;
                    busy     <= 1'b0;
                end
                IDLE: begin
                    if (grant0 || grant1) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        last_grant <= grant1;
                        write_flag <= cmd_write;
                        rf_rw      <= cmd_write;
                        rf_da      <= cmd_da;
                        rf_aa      <= cmd_aa;
                        rf_ba      <= cmd_ba;
                        rf_wdata   <= cmd_wdata;
                    end
                end
                ISSUE: begin
                    if (write_flag) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_a     <= rf_aout;
                    rsp_b     <= rf_bout;
                    rsp_d     <= rf_dout;
                    rsp_id    <= last_grant;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state    <= INIT;
                    rf_reset <= 1'b1;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter
//
// Bench for rf_access_arbiter. It contains a behavioural register file
// (initialised to Rn = n) and a cycle-indexed reference model. The model
// schedules outputs from the grant cycle: rf_rw one cycle later for writes,
// and the response three cycles later for reads. A single compare process
// checks every cycle, and the directed scenarios pin the model with literal
// values.
module tb_rf_access_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_da, req0_aa, req0_ba;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_da, req1_aa, req1_ba;
    logic [DW-1:0] req1_wdata;
    logic          rsp_valid, rsp_id;
    logic [DW-1:0] rsp_a, rsp_b, rsp_d;
    logic          rf_reset, rf_rw;
    logic [AW-1:0] rf_da, rf_aa, rf_ba;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_aout, rf_bout, rf_dout;
    logic          busy;

    rf_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_da(req0_da), .req0_aa(req0_aa), .req0_ba(req0_ba), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_da(req1_da), .req1_aa(req1_aa), .req1_ba(req1_ba), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_d(rsp_d),
        .rf_reset(rf_reset), .rf_rw(rf_rw),
        .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_wdata(rf_wdata),
        .rf_aout(rf_aout), .rf_bout(rf_bout), .rf_dout(rf_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file with registered read outputs.
    logic [DW-1:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_reset) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= DW'(i);
        end else if (rf_rw) begin
            rf_mem[rf_da] <= rf_wdata;
        end else begin
            rf_aout <= rf_mem[rf_aa];
            rf_bout <= rf_mem[rf_ba];
            rf_dout <= rf_mem[rf_da];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Activity observed on the DUT, used by the directed literal checks.
    int grant_log[$];
    int rsp_log[$];
    int rsp_cnt = 0;
    int rsp_cyc = -1;
    int rw_cnt  = 0;
    logic [AW-1:0] w_da;
    logic [DW-1:0] w_data;

    initial begin : compare
        int init_until, free_cyc, last_id, pend_kind, pend_cyc, pend_id, id;
        logic wr, idle, e0, e1, erw, ersp, er_id;
        logic [AW-1:0] da, aa, ba, pend_da;
        logic [DW-1:0] wd, pend_wd, pend_a, pend_b, pend_d, er_a, er_b, er_d;
        logic [DW-1:0] mregs [16];
        init_until = 0; free_cyc = 0; last_id = 1; pend_kind = 0; pend_cyc = 0; pend_id = 0;
        er_id = 1'b0; er_a = '0; er_b = '0; er_d = '0;
        forever begin
            @(negedge clk);
            if (req0_ready) grant_log.push_back(0);
            if (req1_ready) grant_log.push_back(1);
            if (rsp_valid) begin
                rsp_log.push_back(int'(rsp_id));
                rsp_cnt++;
                rsp_cyc = cyc;
            end
            if (rf_rw) begin
                rw_cnt++;
                w_da   = rf_da;
                w_data = rf_wdata;
            end
            if (!reset_n) begin
                chk("rst_rf_reset", 32'(rf_reset), 32'd1);
                chk("rst_busy", 32'(busy), 32'd1);
                chk("rst_rf_rw", 32'(rf_rw), 32'd0);
                chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_id", 32'(rsp_id), 32'd0);
                chk("rst_rsp_abd", {rsp_a, rsp_b | rsp_d}, 32'd0);
                chk("rst_rf_cmd", {rf_wdata, 4'd0, rf_da, rf_aa, rf_ba}, 32'd0);
                last_id    = 1;
                pend_kind  = 0;
                init_until = cyc + 1;
                free_cyc   = cyc + 2;
                er_id = 1'b0; er_a = '0; er_b = '0; er_d = '0;
                for (int i = 0; i < 16; i++) mregs[i] = DW'(i);
            end else begin
                idle = (cyc >= free_cyc);
                e0   = idle && req0_valid && (!req1_valid || last_id == 1);
                e1   = idle && req1_valid && (!req0_valid || last_id == 0);
                erw  = (pend_kind == 1) && (cyc == pend_cyc + 1);
                ersp = (pend_kind == 2) && (cyc == pend_cyc + 3);
                if (ersp) begin
                    er_a  = pend_a;
                    er_b  = pend_b;
                    er_d  = pend_d;
                    er_id = pend_id[0];
                end
                chk("rf_reset", 32'(rf_reset), 32'(cyc <= init_until));
                chk("busy", 32'(busy), 32'(!idle));
                chk("req0_ready", 32'(req0_ready), 32'(e0));
                chk("req1_ready", 32'(req1_ready), 32'(e1));
                chk("rf_rw", 32'(rf_rw), 32'(erw));
                chk("rsp_valid", 32'(rsp_valid), 32'(ersp));
                chk("rsp_id", 32'(rsp_id), 32'(er_id));
                chk("rsp_a", 32'(rsp_a), 32'(er_a));
                chk("rsp_b", 32'(rsp_b), 32'(er_b));
                chk("rsp_d", 32'(rsp_d), 32'(er_d));
                if (erw) begin
                    chk("rf_da", 32'(rf_da), 32'(pend_da));
                    chk("rf_wdata", 32'(rf_wdata), 32'(pend_wd));
                end
                if (e0 || e1) begin
                    id = e1 ? 1 : 0;
                    wr = e1 ? req1_write : req0_write;
                    da = e1 ? req1_da : req0_da;
                    aa = e1 ? req1_aa : req0_aa;
                    ba = e1 ? req1_ba : req0_ba;
                    wd = e1 ? req1_wdata : req0_wdata;
                    pend_cyc = cyc;
                    pend_id  = id;
                    last_id  = id;
                    if (wr) begin
                        pend_kind = 1;
                        pend_da   = da;
                        pend_wd   = wd;
                        mregs[da] = wd;
                        free_cyc  = cyc + 2;
                    end else begin
                        pend_kind = 2;
                        pend_a    = mregs[aa];
                        pend_b    = mregs[ba];
                        pend_d    = mregs[da];
                        free_cyc  = cyc + 3;
                    end
                end
            end
        end
    end

    task automatic issue(input int id, input logic wr, input logic [AW-1:0] da,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                         input logic [DW-1:0] wd, output int gcyc);
        @(posedge clk);
        #2;
        if (id == 0) begin
            req0_write = wr; req0_da = da; req0_aa = aa; req0_ba = ba; req0_wdata = wd;
            req0_valid = 1'b1;
        end else begin
            req1_write = wr; req1_da = da; req1_aa = aa; req1_ba = ba; req1_wdata = wd;
            req1_valid = 1'b1;
        end
        gcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout requester=%0d actual=no_ready required=ready", id);
        end
        @(posedge clk);
        #2;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic id, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] d);
        bit seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid");
        end else begin
            chk("lit_rsp_id", 32'(rsp_id), 32'(id));
            chk("lit_rsp_a", 32'(rsp_a), 32'(a));
            chk("lit_rsp_b", 32'(rsp_b), 32'(b));
            chk("lit_rsp_d", 32'(rsp_d), 32'(d));
            @(negedge clk);
            chk("lit_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g1, g2, g3, base, n0, r0;
        reset_n = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_da = '0; req0_aa = '0; req0_ba = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_da = '0; req1_aa = '0; req1_ba = '0; req1_wdata = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("lit_init_rf_reset", 32'(rf_reset), 32'd1);
        @(negedge clk);
        chk("lit_idle_rf_reset", 32'(rf_reset), 32'd0);
        chk("lit_idle_busy", 32'(busy), 32'd0);

        // Read R5 straight after init.
        issue(0, 1'b0, 4'd5, 4'd5, 4'd5, 16'h0, g1);
        wait_rsp(1'b0, 16'h0005, 16'h0005, 16'h0005);

        // Write R3, then read it back with BA = R4.
        issue(0, 1'b1, 4'd3, 4'd0, 4'd0, 16'hBEEF, g1);
        issue(0, 1'b0, 4'd3, 4'd3, 4'd4, 16'h0, g1);
        wait_rsp(1'b0, 16'hBEEF, 16'h0004, 16'hBEEF);

        // A lone write from requester 1 gives exactly one rf_rw cycle.
        n0 = rw_cnt;
        issue(1, 1'b1, 4'd7, 4'd0, 4'd0, 16'h1234, g1);
        repeat (4) @(negedge clk);
        chk("lit_rw_cycles", 32'(rw_cnt - n0), 32'd1);
        chk("lit_rw_da", 32'(w_da), 32'd7);
        chk("lit_rw_wdata", 32'(w_data), 32'h1234);

        // Both requesters read continuously; the grants alternate.
        base = grant_log.size();
        r0   = rsp_log.size();
        fork
            begin
                issue(0, 1'b0, 4'd1, 4'd7, 4'd3, 16'h0, g2);
                issue(0, 1'b0, 4'd2, 4'd2, 4'd2, 16'h0, g2);
            end
            begin
                issue(1, 1'b0, 4'd7, 4'd8, 4'd9, 16'h0, g3);
                issue(1, 1'b0, 4'd3, 4'd15, 4'd0, 16'h0, g3);
            end
        join
        repeat (5) @(negedge clk);
        chk("lit_rr_count", 32'(grant_log.size() - base), 32'd4);
        if (grant_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) chk("lit_rr_grant", 32'(grant_log[base + k]), 32'(k % 2));
        end
        if (rsp_log.size() >= r0 + 4) begin
            for (int k = 0; k < 4; k++) chk("lit_rr_rsp_id", 32'(rsp_log[r0 + k]), 32'(k % 2));
        end else begin
            chk("lit_rr_rsp_count", 32'(rsp_log.size() - r0), 32'd4);
        end

        // Reset pulse during the ISSUE cycle of a write aborts it.
        n0 = rw_cnt;
        r0 = rsp_cnt;
        issue(0, 1'b1, 4'd2, 4'd0, 4'd0, 16'hAAAA, g1);
        reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("lit_abort_no_write", 32'(rw_cnt - n0), 32'd0);
        chk("lit_abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        issue(0, 1'b0, 4'd2, 4'd2, 4'd2, 16'h0, g1);
        wait_rsp(1'b0, 16'h0002, 16'h0002, 16'h0002);

        // A read followed immediately by a write: the second grant lands in
        // the cycle that carries the read's response strobe.
        issue(0, 1'b0, 4'd7, 4'd7, 4'd3, 16'h0, g1);
        issue(0, 1'b1, 4'd9, 4'd0, 4'd0, 16'h5A5A, g2);
        chk("lit_b2b_grant_cycle", 32'(g2 - g1), 32'd3);
        chk("lit_b2b_rsp_cycle", 32'(rsp_cyc), 32'(g2));
        issue(1, 1'b0, 4'd9, 4'd9, 4'd9, 16'h0, g1);
        wait_rsp(1'b1, 16'h5A5A, 16'h5A5A, 16'h5A5A);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
